// File: rtl/salamander_pkg.sv
// Types shared by the memory-port arbiter.
// Covers the arbitration state and the record of which requester owned the port last.
package salamander_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CORE,
        ARB_LOAD
    } arb_state_t;

    typedef enum logic {
        OWN_CORE,
        OWN_LD
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory write/read port between the program loader
// (bursting, write-only) and the CPU core (single-beat read/write).
module mem_port_arbiter
    import salamander_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 5,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ld_req,
    input  logic                 ld_last,
    input  logic [ADDR_SIZE-1:0] ld_addr,
    input  logic [DATA_SIZE-1:0] ld_wdata,
    output logic                 ld_gnt,
    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [ADDR_SIZE-1:0] core_addr,
    input  logic [DATA_SIZE-1:0] core_wdata,
    output logic                 core_gnt,
    output logic                 core_rvalid,
    output logic [DATA_SIZE-1:0] core_rdata,
    output logic                 core_stall,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    arb_owner_t       rr_last_q, rr_last_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             core_rvalid_q, core_rvalid_d;
    logic             burst_end;

    // Grants come only from registered state, so they can never both be high.
    assign ld_gnt      = rstn && (state_q == ARB_LOAD) && ld_req;
    assign core_gnt    = rstn && (state_q == ARB_CORE) && core_req;
    assign core_stall  = (state_q == ARB_LOAD);
    assign core_rdata  = mem_rdata;
    assign core_rvalid = core_rvalid_q;
    assign burst_end   = (beat_cnt_q == CNT_LAST);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ARB_LOAD: begin
                mem_we    = ld_gnt;
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
            end
            ARB_CORE: begin
                mem_we    = core_gnt && core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        beat_cnt_d    = beat_cnt_q;
        core_rvalid_d = core_gnt && !core_we;
        case (state_q)
            ARB_IDLE: begin
                if (ld_req && (!core_req || rr_last_q == OWN_CORE)) begin
                    state_d    = ARB_LOAD;
                    beat_cnt_d = '0;
                end else if (core_req) begin
                    state_d = ARB_CORE;
                end
            end
            ARB_LOAD: begin
                if (ld_gnt && (ld_last || burst_end) && core_req) begin
                    state_d    = ARB_CORE;
                    rr_last_d  = OWN_LD;
                    beat_cnt_d = '0;
                end else if ((ld_gnt && ld_last) || !ld_req) begin
                    state_d    = ARB_IDLE;
                    rr_last_d  = OWN_LD;
                    beat_cnt_d = '0;
                end else if (burst_end) begin
                    // Nobody else is waiting: loader keeps the port and starts a fresh burst window.
                    beat_cnt_d = '0;
                end else if (ld_gnt) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            ARB_CORE: begin
                if (ld_req) begin
                    state_d    = ARB_LOAD;
                    rr_last_d  = OWN_CORE;
                    beat_cnt_d = '0;
                end else if (!core_req) begin
                    state_d   = ARB_IDLE;
                    rr_last_d = OWN_CORE;
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ARB_IDLE;
            rr_last_q     <= OWN_CORE;
            beat_cnt_q    <= '0;
            core_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            beat_cnt_q    <= beat_cnt_d;
            core_rvalid_q <= core_rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a small synchronous-read memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rstn;
    logic        ld_req, ld_last, ld_gnt;
    logic [4:0]  ld_addr;
    logic [15:0] ld_wdata;
    logic        core_req, core_we, core_gnt, core_rvalid, core_stall;
    logic [4:0]  core_addr;
    logic [15:0] core_wdata, core_rdata;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] tb_mem [32];

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.DATA_SIZE(16), .ADDR_SIZE(5), .MAX_BURST(4)) dut (
        .clk(clk), .rstn(rstn),
        .ld_req(ld_req), .ld_last(ld_last), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_stall(core_stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string tag);
        @(negedge clk);
        $display("[%0t] %s: ld_gnt=%b core_gnt=%b we=%b addr=%0d wdata=%h stall=%b rvalid=%b rdata=%h",
                 $time, tag, ld_gnt, core_gnt, mem_we, mem_addr, mem_wdata, core_stall, core_rvalid, core_rdata);
    endtask

    task automatic drop_all();
        ld_req = 0; ld_last = 0; core_req = 0; core_we = 0;
    endtask

    task automatic test_reset();
        rstn = 0; ld_req = 1; core_req = 1;
        for (int i = 0; i < 2; i++) begin
            sample("reset");
            total++; if (ld_gnt !== 1'b0) begin bad++; $display("FAIL reset_ld_gnt: got %b want 0", ld_gnt); end
            total++; if (core_gnt !== 1'b0) begin bad++; $display("FAIL reset_core_gnt: got %b want 0", core_gnt); end
            total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
            next_cycle();
        end
        rstn = 1;
        sample("release");
        total++; if (ld_gnt !== 1'b0 || core_gnt !== 1'b0) begin bad++; $display("FAIL release_gnts: got ld=%b core=%b want 0 0", ld_gnt, core_gnt); end
        total++; if (core_stall !== 1'b0 || core_rvalid !== 1'b0) begin bad++; $display("FAIL release_idle: got stall=%b rvalid=%b want 0 0", core_stall, core_rvalid); end
        next_cycle();
    endtask

    // First tie after reset went to the loader; the next tie must go to the core.
    task automatic test_tie();
        ld_last = 1; ld_addr = 5; ld_wdata = 16'h5A5A; core_req = 0;
        sample("tie1");
        total++; if (ld_gnt !== 1'b1 || core_gnt !== 1'b0) begin bad++; $display("FAIL tie1_winner: got ld=%b core=%b want 1 0", ld_gnt, core_gnt); end
        next_cycle();
        ld_last = 0; ld_req = 1; core_req = 1; core_we = 0; core_addr = 5;
        sample("tie2_idle");
        total++; if (ld_gnt !== 1'b0 || core_gnt !== 1'b0) begin bad++; $display("FAIL tie2_bubble: got ld=%b core=%b want 0 0", ld_gnt, core_gnt); end
        next_cycle();
        ld_req = 0;
        sample("tie2");
        total++; if (core_gnt !== 1'b1 || ld_gnt !== 1'b0) begin bad++; $display("FAIL tie2_winner: got ld=%b core=%b want 0 1", ld_gnt, core_gnt); end
        next_cycle();
        core_req = 0;
        sample("tie2_rd");
        total++; if (core_rvalid !== 1'b1 || core_rdata !== 16'h5A5A) begin bad++; $display("FAIL tie2_read: got rvalid=%b rdata=%h want 1 5a5a", core_rvalid, core_rdata); end
        next_cycle();
    endtask

    task automatic test_loader_alone();
        logic [15:0] d [3] = '{16'h4012, 16'h1023, 16'h9410};
        int stall_cnt = 0;
        drop_all();
        ld_req = 1; ld_addr = 0; ld_wdata = d[0];
        sample("ld_bubble");
        total++; if (ld_gnt !== 1'b0 || core_stall !== 1'b0) begin bad++; $display("FAIL ld_bubble: got gnt=%b stall=%b want 0 0", ld_gnt, core_stall); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            ld_addr = 5'(i); ld_wdata = d[i]; ld_last = (i == 2);
            sample("ld_beat");
            if (core_stall) stall_cnt++;
            total++;
            if (ld_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'(i) || mem_wdata !== d[i]) begin
                bad++; $display("FAIL ld_beat%0d: got gnt=%b we=%b addr=%0d data=%h want 1 1 %0d %h", i, ld_gnt, mem_we, mem_addr, mem_wdata, i, d[i]);
            end
            next_cycle();
        end
        drop_all();
        sample("ld_done");
        total++; if (core_stall !== 1'b0 || ld_gnt !== 1'b0) begin bad++; $display("FAIL ld_done_idle: got stall=%b gnt=%b want 0 0", core_stall, ld_gnt); end
        total++; if (stall_cnt != 3) begin bad++; $display("FAIL ld_stall_cycles: got %0d want 3", stall_cnt); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            total++; if (tb_mem[i] !== d[i]) begin bad++; $display("FAIL ld_mem%0d: got %h want %h", i, tb_mem[i], d[i]); end
        end
    endtask

    task automatic test_contention();
        drop_all();
        ld_req = 1; ld_addr = 8; ld_wdata = 16'h8000;
        sample("ct_bubble");
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            ld_addr = 5'(8 + b); ld_wdata = 16'h8000 + 16'(b);
            if (b == 0) begin core_req = 1; core_we = 0; core_addr = 1; end
            sample("ct_ld");
            total++;
            if (ld_gnt !== 1'b1 || core_gnt !== 1'b0 || core_stall !== 1'b1) begin
                bad++; $display("FAIL ct_beat%0d: got ld=%b core=%b stall=%b want 1 0 1", b, ld_gnt, core_gnt, core_stall);
            end
            next_cycle();
        end
        ld_addr = 12; ld_wdata = 16'h8004;
        sample("ct_core");
        total++;
        if (core_gnt !== 1'b1 || ld_gnt !== 1'b0 || mem_addr !== 5'd1 || mem_we !== 1'b0 || core_stall !== 1'b0) begin
            bad++; $display("FAIL ct_handoff: got core=%b ld=%b addr=%0d we=%b stall=%b want 1 0 1 0 0", core_gnt, ld_gnt, mem_addr, mem_we, core_stall);
        end
        next_cycle();
        core_req = 0;
        sample("ct_resume");
        total++; if (ld_gnt !== 1'b1 || mem_addr !== 5'd12) begin bad++; $display("FAIL ct_resume: got gnt=%b addr=%0d want 1 12", ld_gnt, mem_addr); end
        total++; if (core_rvalid !== 1'b1 || core_rdata !== 16'h1023) begin bad++; $display("FAIL ct_rdata: got rvalid=%b rdata=%h want 1 1023", core_rvalid, core_rdata); end
        next_cycle();
        ld_addr = 13; ld_wdata = 16'h8005; ld_last = 1;
        sample("ct_last");
        total++; if (ld_gnt !== 1'b1 || core_rvalid !== 1'b0) begin bad++; $display("FAIL ct_last: got gnt=%b rvalid=%b want 1 0", ld_gnt, core_rvalid); end
        next_cycle();
        drop_all();
        sample("ct_idle");
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL ct_idle_stall: got %b want 0", core_stall); end
        next_cycle();
        total++; if (tb_mem[12] !== 16'h8004 || tb_mem[13] !== 16'h8005) begin bad++; $display("FAIL ct_mem: got %h %h want 8004 8005", tb_mem[12], tb_mem[13]); end
    endtask

    task automatic test_back_to_back();
        drop_all();
        core_req = 1; core_we = 1; core_addr = 3; core_wdata = 16'hABCD;
        sample("bb_bubble");
        total++; if (core_gnt !== 1'b0) begin bad++; $display("FAIL bb_bubble: got %b want 0", core_gnt); end
        next_cycle();
        sample("bb_wr");
        total++;
        if (core_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'd3 || mem_wdata !== 16'hABCD) begin
            bad++; $display("FAIL bb_write: got gnt=%b we=%b addr=%0d data=%h want 1 1 3 abcd", core_gnt, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        core_we = 0;
        sample("bb_rd");
        total++; if (core_gnt !== 1'b1 || mem_we !== 1'b0 || core_rvalid !== 1'b0) begin bad++; $display("FAIL bb_read: got gnt=%b we=%b rvalid=%b want 1 0 0", core_gnt, mem_we, core_rvalid); end
        next_cycle();
        core_req = 0;
        sample("bb_data");
        total++; if (core_rvalid !== 1'b1 || core_rdata !== 16'hABCD) begin bad++; $display("FAIL bb_rdata: got rvalid=%b rdata=%h want 1 abcd", core_rvalid, core_rdata); end
        next_cycle();
        sample("bb_idle");
        total++; if (core_rvalid !== 1'b0 || core_gnt !== 1'b0) begin bad++; $display("FAIL bb_idle: got rvalid=%b gnt=%b want 0 0", core_rvalid, core_gnt); end
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        drop_all();
        ld_req = 1; ld_addr = 16; ld_wdata = 16'h1600;
        sample("mr_bubble");
        next_cycle();
        for (int b = 0; b < 2; b++) begin
            ld_addr = 5'(16 + b); ld_wdata = 16'h1600 + 16'(b);
            sample("mr_beat");
            total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL mr_beat%0d: got %b want 1", b, ld_gnt); end
            next_cycle();
        end
        ld_addr = 18; ld_wdata = 16'h1602; rstn = 0;
        sample("mr_reset");
        total++; if (ld_gnt !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL mr_reset_gnt: got gnt=%b we=%b want 0 0", ld_gnt, mem_we); end
        next_cycle();
        rstn = 1; core_req = 1; core_we = 0; core_addr = 16;
        sample("mr_idle");
        total++; if (ld_gnt !== 1'b0 || core_gnt !== 1'b0 || core_stall !== 1'b0) begin bad++; $display("FAIL mr_idle: got ld=%b core=%b stall=%b want 0 0 0", ld_gnt, core_gnt, core_stall); end
        next_cycle();
        // A fresh count gives four beats before the waiting core is handed the port.
        for (int k = 0; k < 4; k++) begin
            ld_addr = 5'(18 + k); ld_wdata = 16'h1602 + 16'(k);
            sample("mr_reissue");
            total++; if (ld_gnt !== 1'b1 || core_gnt !== 1'b0) begin bad++; $display("FAIL mr_reissue%0d: got ld=%b core=%b want 1 0", k, ld_gnt, core_gnt); end
            next_cycle();
        end
        ld_addr = 22;
        sample("mr_handoff");
        total++; if (core_gnt !== 1'b1 || ld_gnt !== 1'b0) begin bad++; $display("FAIL mr_handoff: got core=%b ld=%b want 1 0", core_gnt, ld_gnt); end
        next_cycle();
        drop_all();
        sample("mr_rdata");
        total++; if (core_rvalid !== 1'b1 || core_rdata !== 16'h1600) begin bad++; $display("FAIL mr_rdata: got rvalid=%b rdata=%h want 1 1600", core_rvalid, core_rdata); end
        next_cycle();
        next_cycle();
    endtask

    initial begin
        rstn = 0;
        ld_req = 0; ld_last = 0; ld_addr = '0; ld_wdata = '0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        for (int i = 0; i < 32; i++) tb_mem[i] = '0;
        next_cycle();
        test_reset();
        test_tie();
        test_loader_alone();
        test_contention();
        test_back_to_back();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
